truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Upstream stimulus stage and downstream capture stage for the 3-input, 1-output blackbox in Lab1.
//   On start, drives all 8 {z,k,r} combinations in binary order, 000 first, then 001, up to 111.
//   Holds each combination for HOLD_CYCLES clocks, then samples output a at the end of the hold.
//   Packs the samples into an 8-bit truth table and compares it with an expected table.
//   Replaces the hand-written #10 vector list with a synthesizable, self-checking sweep.
// PARAMETERS
//   HOLD_CYCLES  10  clocks each vector is held before a is sampled; legal range 1..255
//   HOLD_W       8   width of the hold counter; must satisfy 2**HOLD_W > HOLD_CYCLES-1
// PORTS
//   clock     in   1  rising-edge clock
//   reset     in   1  asynchronous, active-high reset
//   start     in   1  one-cycle request to begin a sweep
//   expected  in   8  reference truth table; bit i = required a for {z,k,r}==i
//   a         in   1  blackbox output under test
//   z         out  1  blackbox input, vector bit 2 (MSB)
//   k         out  1  blackbox input, vector bit 1
//   r         out  1  blackbox input, vector bit 0 (LSB)
//   table_q   out  8  captured truth table; bit i = sampled a for vector i
//   busy      out  1  high while a sweep is in progress
//   done      out  1  sweep complete; sticky until the next accepted start or reset
//   pass      out  1  table_q==expected; valid only while done=1
//   first_bad out  3  lowest index i where table_q[i]!=expected[i]; 0 when pass=1
// BEHAVIOUR
//   Reset (asynchronous, any state):
//     - state=IDLE; z,k,r,table_q,busy,done,pass,first_bad all 0; idx=0; hold=0.
//   FSM states: IDLE, DRIVE, DONE. Registered, one-hot or binary.
//   IDLE:
//     - start=1 at edge E0 -> DRIVE; idx=0, hold=0, table_q=0, busy=1.
//   DRIVE:
//     - {z,k,r} = idx, driven directly from the idx register.
//     - Each edge: hold increments.
//     - At the edge where hold==HOLD_CYCLES-1: table_q[idx] <= a, hold <= 0.
//       - If idx==7 -> DONE.
//       - Otherwise idx increments.
//     - Vector i is therefore driven for exactly HOLD_CYCLES clocks.
//     - a is sampled on the last of those clocks, giving the DUT HOLD_CYCLES-1 cycles to settle.
//     - start is ignored while in DRIVE.
//     - expected must stay stable from the accepted start until done.
//   DONE:
//     - Entered at edge E0 + 8*HOLD_CYCLES.
//     - On entry: busy=0, done=1.
//     - pass and first_bad are registered on the entry edge, using the final table including bit 7.
//     - {z,k,r} return to 000.
//     - start=1 -> same action as IDLE+start: clears done, pass, first_bad and table_q, then sweeps again.
//   Boundary cases:
//     - HOLD_CYCLES=1 samples a on the same edge the vector advances; one vector per clock.
//     - idx never wraps: the sweep always terminates after 111.
//     - Reset mid-sweep aborts the sweep; done is not asserted.
//     - start held high for several cycles is accepted once only.
//       A later start is accepted only from IDLE or DONE.
//     - first_bad: priority encoder over (table_q ^ expected), lowest set bit wins.
// STRUCTURE
//   sweeper_defs.vh (shared include):
//     - state encodings ST_IDLE, ST_DRIVE, ST_DONE
//     - NUM_VECTORS=8, VEC_W=3
//   Sub-module hold_timer #(HOLD_CYCLES, HOLD_W):
//     - Ports: clock, reset, clear, enable -> expire (1 when hold==HOLD_CYCLES-1 and enable).
//     - Top level holds the FSM, idx, capture register and compare/priority logic.
// TESTING
//   1. a = z&k&r model, HOLD=10, expected=8'h80:
//        done at E0+80, table_q=80, pass=1, first_bad=0.
//   2. a = z^k^r model, expected=8'h96:
//        pass=1; check z,k,r each change exactly every 10 clocks in order 0..7.
//   3. Same XOR model, expected=8'h97:
//        pass=0, first_bad=0, table_q=96.
//   4. Assert reset at E0+35 (mid-vector 3):
//        all outputs 0 immediately, no done; a fresh start then completes normally.
//   5. start pulsed at E0+20 while busy:
//        ignored; done still at E0+80; start in DONE restarts with table_q cleared.
//   6. HOLD_CYCLES=1, a = ~z:
//        done at E0+8, table_q=8'h0F.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_pkg
//   Shared definitions for the truth-table sweeper: vector count/width, the
//   FSM state encoding and a lowest-set-bit helper used to locate the first
//   mismatching truth-table entry.
// -----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    // Index of the lowest set bit of v; 0 when v is all zero.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [NUM_VECTORS-1:0] v);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (v[i]) r = VEC_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
//   Bundles the sweep request, the blackbox stimulus/response pins and the
//   result signals of the truth-table sweeper.
//
//   Handshake: start is a one-cycle request. It is accepted on any rising
//   clock edge where the sweeper is not busy (state IDLE or DONE); while busy
//   is high start is ignored, so a held start is taken exactly once. expected
//   must stay stable from the accepted start until done rises.
//
//   slave  : the sweeper (takes start/expected/a, drives z,k,r and results)
//   master : the requester / blackbox side
//   state  : debug view of the sweeper FSM
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if;
    import truth_table_sweeper_pkg::*;

    logic                   start;
    logic [NUM_VECTORS-1:0] expected;
    logic                   a;
    logic                   z;
    logic                   k;
    logic                   r;
    logic [NUM_VECTORS-1:0] table_q;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [VEC_W-1:0]       first_bad;
    sweep_state_e           state;

    modport slave (
        input  start, expected, a,
        output z, k, r, table_q, busy, done, pass, first_bad, state
    );

    modport master (
        output start, expected, a,
        input  z, k, r, table_q, busy, done, pass, first_bad, state
    );

endinterface

// File: rtl/truth_table_sweeper_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
//   Counts the clocks a vector has been held. expire is high on the clock
//   where the count has reached HOLD_CYCLES-1 while enabled; the counter
//   wraps to 0 on that same edge so the next vector starts a fresh hold.
//
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   clear  : synchronous clear of the hold count (start of a sweep)
//   enable : count this clock
//   expire : last clock of the current hold
// -----------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_CYCLES = 10,
    parameter int HOLD_W      = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [HOLD_W-1:0] hold_q;

    assign expire = enable && (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else if (clear) begin
            hold_q <= '0;
        end else if (enable) begin
            hold_q <= expire ? '0 : hold_q + HOLD_W'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//   Drives all eight {z,k,r} combinations into a 3-input blackbox in binary
//   order, holding each for HOLD_CYCLES clocks and sampling a on the last
//   clock of the hold. The samples build an 8-bit truth table that is compared
//   against bus.expected when the sweep finishes.
//
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : start/expected/a in; z,k,r, table_q, busy, done, pass,
//           first_bad and debug state out
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int HOLD_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    truth_table_sweeper_if.slave bus
);

    sweep_state_e           state_q, state_d;
    logic [VEC_W-1:0]       idx_q, idx_d;
    logic [NUM_VECTORS-1:0] table_r, table_d;
    logic                   pass_r, pass_d;
    logic [VEC_W-1:0]       first_bad_r, first_bad_d;
    logic [NUM_VECTORS-1:0] captured;
    logic                   timer_clear;
    logic                   timer_en;
    logic                   expire;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W)
    ) u_hold_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (expire)
    );

    // Table as it will be after this edge's sample; used so pass/first_bad on
    // the DONE entry edge already include bit 7.
    always_comb begin
        captured         = table_r;
        captured[idx_q]  = bus.a;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        table_d     = table_r;
        pass_d      = pass_r;
        first_bad_d = first_bad_r;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_DRIVE;
                    idx_d       = '0;
                    table_d     = '0;
                    pass_d      = 1'b0;
                    first_bad_d = '0;
                    timer_clear = 1'b1;
                end
            end
            ST_DRIVE: begin
                timer_en = 1'b1;
                if (expire) begin
                    table_d = captured;
                    if (idx_q == VEC_W'(NUM_VECTORS - 1)) begin
                        state_d     = ST_DONE;
                        // idx returns home so z,k,r read 000 while done.
                        idx_d       = '0;
                        pass_d      = (captured == bus.expected);
                        first_bad_d = lowest_set(captured ^ bus.expected);
                    end else begin
                        idx_d = idx_q + VEC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            table_r     <= '0;
            pass_r      <= 1'b0;
            first_bad_r <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            table_r     <= table_d;
            pass_r      <= pass_d;
            first_bad_r <= first_bad_d;
        end
    end

    // The vector pins come straight from the idx register.
    assign bus.z         = idx_q[2];
    assign bus.k         = idx_q[1];
    assign bus.r         = idx_q[0];
    assign bus.table_q   = table_r;
    assign bus.busy      = (state_q == ST_DRIVE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = pass_r;
    assign bus.first_bad = first_bad_r;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  typedef struct packed {
    logic [2:0] vec;
    logic [7:0] tbl;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fb;
  } obs_t;

  logic       clock;
  logic       reset;
  logic [7:0] lut0;
  logic [7:0] lut1;
  int         total;
  int         bad;
  logic [11:0] exp_q[$];

  truth_table_sweeper_if bus0();
  truth_table_sweeper_if bus1();

  // Blackboxes: a combinational lookup on the driven vector.
  assign bus0.a = lut0[{bus0.z, bus0.k, bus0.r}];
  assign bus1.a = lut1[{bus1.z, bus1.k, bus1.r}];

  truth_table_sweeper #(.HOLD_CYCLES(10), .HOLD_W(8)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1), .HOLD_W(8)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic obs_t observe(input int u);
    obs_t o;
    if (u == 0) o = '{vec: {bus0.z, bus0.k, bus0.r}, tbl: bus0.table_q, busy: bus0.busy,
                      done: bus0.done, pass: bus0.pass, fb: bus0.first_bad};
    else        o = '{vec: {bus1.z, bus1.k, bus1.r}, tbl: bus1.table_q, busy: bus1.busy,
                      done: bus1.done, pass: bus1.pass, fb: bus1.first_bad};
    return o;
  endfunction

  // ---------------- reference model ----------------
  // Truth table of a named blackbox function: 0 = z&k&r, 1 = z^k^r, 2 = ~z.
  function automatic logic [7:0] bb_lut(input int kind);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      bit zz, kk, rr;
      zz = ((i / 4) % 2) == 1;
      kk = ((i / 2) % 2) == 1;
      rr = (i % 2) == 1;
      case (kind)
        0:       t[i] = zz & kk & rr;
        1:       t[i] = zz ^ kk ^ rr;
        default: t[i] = !zz;
      endcase
    end
    return t;
  endfunction

  // Expected {table, pass, first_bad} for a sweep over a blackbox with truth table lut.
  function automatic logic [11:0] model(input logic [7:0] lut, input logic [7:0] exp);
    logic [7:0] tbl;
    logic [2:0] fb;
    bit         found;
    tbl = '0;
    fb = '0;
    found = 0;
    for (int i = 0; i < 8; i++) tbl[i] = lut[i];
    for (int i = 0; i < 8; i++) begin
      if (!found && tbl[i] != exp[i]) begin
        fb = 3'(i);
        found = 1;
      end
    end
    return {tbl, !found, fb};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_start(input int u, input logic v);
    if (u == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  task automatic set_case(input int u, input logic [7:0] lut, input logic [7:0] exp);
    if (u == 0) begin lut0 = lut; bus0.expected = exp; end
    else        begin lut1 = lut; bus1.expected = exp; end
  endtask

  // One complete sweep: start held start_len cycles from E0, optional single
  // extra start pulse sampled at edge E0+pulse_at while busy.
  task automatic run_sweep(input int u, input int hold, input logic [7:0] lut,
                           input logic [7:0] exp, input int start_len,
                           input int pulse_at, input bit chk_vec);
    obs_t        o;
    bit          got_done;
    logic [11:0] e;
    set_case(u, lut, exp);
    exp_q.push_back(model(lut, exp));
    @(negedge clock);
    drive_start(u, 1'b1);
    @(posedge clock);
    #1;
    o = observe(u);
    check("accept_busy", 32'(o.busy), 32'd1);
    check("accept_done_clr", 32'(o.done), 32'd0);
    check("accept_tbl_clr", 32'(o.tbl), 32'd0);
    check("accept_pass_clr", 32'(o.pass), 32'd0);
    check("accept_vec0", 32'(o.vec), 32'd0);
    drive_start(u, (1 < start_len) || (1 == pulse_at));
    got_done = 0;
    for (int c = 1; c <= 8 * hold + 5 && !got_done; c++) begin
      @(posedge clock);
      #1;
      o = observe(u);
      drive_start(u, (c + 1 < start_len) || (c + 1 == pulse_at));
      if (o.done) begin
        got_done = 1;
        check("done_latency", 32'(c), 32'(8 * hold));
      end else if (chk_vec) begin
        check("vec_seq", 32'(o.vec), 32'(c / hold));
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    e = exp_q.pop_front();
    check("table", 32'(o.tbl), 32'(e[11:4]));
    check("pass", 32'(o.pass), 32'(e[3]));
    check("first_bad", 32'(o.fb), 32'(e[2:0]));
    check("vec_home", 32'(o.vec), 32'd0);
    check("busy_low", 32'(o.busy), 32'd0);
    drive_start(u, 1'b0);
    @(posedge clock);
    #1;
    o = observe(u);
    check("done_sticky", 32'(o.done), 32'd1);
    check("table_hold", 32'(o.tbl), 32'(e[11:4]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    obs_t o;
    total = 0;
    bad = 0;
    reset = 1'b1;
    lut0 = '0;
    lut1 = '0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus0.expected = '0;
    bus1.expected = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int u = 0; u < 2; u++) begin
      o = observe(u);
      check("rst_vec", 32'(o.vec), 32'd0);
      check("rst_tbl", 32'(o.tbl), 32'd0);
      check("rst_busy", 32'(o.busy), 32'd0);
      check("rst_done", 32'(o.done), 32'd0);
      check("rst_pass", 32'(o.pass), 32'd0);
      check("rst_fb", 32'(o.fb), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    // AND blackbox, matching expectation.
    run_sweep(0, 10, bb_lut(0), 8'h80, 1, -1, 0);
    // XOR blackbox, matching, with full vector-sequence check.
    run_sweep(0, 10, bb_lut(1), 8'h96, 1, -1, 1);
    // XOR blackbox, one wrong expected bit at index 0.
    run_sweep(0, 10, bb_lut(1), 8'h97, 1, -1, 0);

    // Reset in the middle of vector 3.
    set_case(0, bb_lut(1), 8'h96);
    @(negedge clock);
    drive_start(0, 1'b1);
    @(posedge clock);
    #1;
    drive_start(0, 1'b0);
    repeat (35) @(posedge clock);
    #1;
    o = observe(0);
    check("mid_vec", 32'(o.vec), 32'd3);
    check("mid_busy", 32'(o.busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    o = observe(0);
    check("abort_vec", 32'(o.vec), 32'd0);
    check("abort_tbl", 32'(o.tbl), 32'd0);
    check("abort_busy", 32'(o.busy), 32'd0);
    check("abort_done", 32'(o.done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (90) @(posedge clock);
    #1;
    o = observe(0);
    check("abort_no_done", 32'(o.done), 32'd0);
    run_sweep(0, 10, bb_lut(0), 8'h80, 1, -1, 0);

    // Start pulse while busy is ignored; restart from DONE clears results.
    run_sweep(0, 10, bb_lut(1), 8'h96, 1, 20, 1);
    run_sweep(0, 10, 8'h5A, 8'h5A, 3, -1, 0);

    // One vector per clock.
    run_sweep(1, 1, bb_lut(2), 8'h0F, 1, -1, 1);
    run_sweep(1, 1, bb_lut(2), 8'h1F, 2, -1, 1);

    // Randomized sweeps.
    for (int n = 0; n < 12; n++) begin
      int         u;
      logic [7:0] lut;
      logic [7:0] exp;
      u = int'($urandom_range(0, 1));
      lut = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       exp = lut;
        1:       exp = lut ^ (8'd1 << $urandom_range(0, 7));
        default: exp = 8'($urandom);
      endcase
      run_sweep(u, (u == 0) ? 10 : 1, lut, exp, int'($urandom_range(1, 3)), -1,
                1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
